// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen
//   Quadrature signal generator. Walks an internal 32-bit position toward a
//   commanded target one count per A/B edge, with a programmable minimum
//   spacing between edges, and emits a once-per-revolution index pulse.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   enable       1 = edges allowed; 0 = outputs hold (spacing timer keeps running)
//   target       commanded position, two's complement, modular
//   edge_period  minimum clocks between consecutive edges (0 behaves as 1)
//   quadA/quadB  registered quadrature outputs
//   index        registered, high while the emitted count sits at rev_cnt==0
//   pos          current emitted position
//   busy         enable && pos != target (combinational)
//   dbg_state    FSM state for observation: 0 = IDLE, 1 = HOLD
//
// Handshake: there is none; target and edge_period are level inputs that are
// sampled only at a step decision (IDLE state).
module quad_encoder_gen #(
  parameter int CPR      = 2000,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [31:0]         target,
  input  logic [PERIOD_W-1:0] edge_period,
  output logic                quadA,
  output logic                quadB,
  output logic                index,
  output logic [31:0]         pos,
  output logic                busy,
  output logic                dbg_state
);

  localparam int            RW       = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [RW-1:0] REV_LAST = RW'(CPR - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_n;
  logic [PERIOD_W-1:0] timer, timer_n;
  logic [PERIOD_W-1:0] gap_m1;
  logic [RW-1:0]       rev_cnt, rev_n;
  logic [31:0]         pos_n;
  logic [31:0]         diff;

  // Modular distance; its sign bit picks the short way round the 2^32 circle.
  assign diff   = target - pos;
  // Clocks to sit in HOLD after a step; edge_period of 0 collapses to 1.
  assign gap_m1 = (edge_period == '0) ? '0 : edge_period - PERIOD_W'(1);

  always_comb begin
    state_n = state;
    timer_n = timer;
    pos_n   = pos;
    rev_n   = rev_cnt;
    case (state)
      IDLE: begin
        if (enable && (diff != '0)) begin
          if (!diff[31]) begin
            pos_n = pos + 32'd1;
            rev_n = (rev_cnt == REV_LAST) ? '0 : rev_cnt + RW'(1);
          end else begin
            pos_n = pos - 32'd1;
            rev_n = (rev_cnt == '0) ? REV_LAST : rev_cnt - RW'(1);
          end
          timer_n = gap_m1;
          if (gap_m1 != '0) state_n = HOLD;
        end
      end
      HOLD: begin
        // Runs regardless of enable so spacing is preserved across pauses.
        timer_n = timer - PERIOD_W'(1);
        if (timer <= PERIOD_W'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      pos     <= '0;
      rev_cnt <= '0;
      quadA   <= 1'b0;
      quadB   <= 1'b0;
      index   <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      pos     <= pos_n;
      rev_cnt <= rev_n;
      // Gray-coded phase from the low two bits: up order (A,B) 00,10,11,01.
      quadA   <= pos_n[1] ^ pos_n[0];
      quadB   <= pos_n[1];
      index   <= (rev_n == '0);
    end
  end

  assign busy      = enable && (pos != target);
  assign dbg_state = (state == HOLD);

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Testbench for quad_encoder_gen (built with CPR=8 so index positions are short).
module tb_quad_encoder_gen;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] target = '0;
  logic [15:0] edge_period = '0;
  logic        quadA, quadB, index, busy, dbg_state;
  logic [31:0] pos;

  always #5 clk = ~clk;

  quad_encoder_gen #(.CPR(8), .PERIOD_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .target(target),
    .edge_period(edge_period), .quadA(quadA), .quadB(quadB), .index(index),
    .pos(pos), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- loop-back decoder model (3-stage sync, x4) ----------------
  logic        dec_rst = 1'b0;
  logic [2:0]  sa = '0, sb = '0;
  logic        a_old = 1'b0, b_old = 1'b0;
  logic [31:0] dec_pos = '0;

  always @(posedge clk) begin
    if (dec_rst) begin
      sa <= '0; sb <= '0; a_old <= 1'b0; b_old <= 1'b0; dec_pos <= '0;
    end else begin
      sa    <= {sa[1:0], quadA};
      sb    <= {sb[1:0], quadB};
      a_old <= sa[2];
      b_old <= sb[2];
      if ((sa[2] ^ a_old) ^ (sb[2] ^ b_old)) begin
        if (sa[2] ^ b_old) dec_pos <= dec_pos + 32'd1;
        else               dec_pos <= dec_pos - 32'd1;
      end
    end
  end

  // Counts clocks where both A and B changed together.
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   both_cnt = 0;
  always @(negedge clk) begin
    prev_a <= quadA;
    prev_b <= quadB;
    if ((quadA !== prev_a) && (quadB !== prev_b)) both_cnt <= both_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [34:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; dec_rst = 1'b1;
    tick(); tick();
    reset = 1'b0; dec_rst = 1'b0;
  endtask

  task automatic wait_pos(input string tag, input logic [31:0] p, input int budget);
    int n = 0;
    while ((pos !== p) && (n < budget)) begin tick(); n++; end
    check(tag, pos, p);
  endtask

  // Drains exp_q against {index, quadA, quadB, pos} one clock per entry.
  task automatic drain_per_clock(input string tag);
    while (exp_q.size() > 0) begin
      tick();
      check(tag, {index, quadA, quadB, pos}, exp_q.pop_front());
    end
  endtask

  // Walks until pos==stop, collecting pos on every sample with index high,
  // and compares the hits with exp_q.
  task automatic index_walk(input string tag, input logic [31:0] stop, input int budget);
    logic [31:0] hits[$];
    int n = 0;
    while (n < budget) begin
      tick(); n++;
      if (index) hits.push_back(pos);
      if (pos == stop) break;
    end
    check({tag, "_n"}, hits.size(), exp_q.size());
    while (exp_q.size() > 0 && hits.size() > 0)
      check(tag, hits.pop_front(), exp_q.pop_front());
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          edge_t[$];
    logic [1:0]  edge_ab[$];
    logic [31:0] last;
    int          n;
    int          both_base;
    int          exp_t [5] = '{1, 5, 9, 13, 17};
    logic [1:0]  exp_ab[5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};

    // Reset values
    do_reset();
    check("rst_pos", pos, 0);
    check("rst_ab", {quadA, quadB}, 2'b00);
    check("rst_index", index, 1);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);

    // Up walk to 5, spacing 4, first edge one clock after target write
    target = 32'd5; edge_period = 16'd4; enable = 1'b1;
    last = pos;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 1) check("busy_moving", busy, 1);
      if (pos != last) begin
        edge_t.push_back(t);
        edge_ab.push_back({quadA, quadB});
        if (pos == 32'd5) check("busy_at_last_edge", busy, 0);
        last = pos;
      end
    end
    check("up_edge_count", edge_t.size(), 5);
    for (int i = 0; i < 5 && i < edge_t.size(); i++) begin
      check("up_edge_time", edge_t[i], exp_t[i]);
      check("up_edge_ab", edge_ab[i], exp_ab[i]);
    end
    check("up_final_pos", pos, 5);

    // Back to 3 with edge_period=0 (acts as 1): edges on consecutive clocks
    target = 32'd3; edge_period = 16'd0;
    exp_q.push_back({1'b0, 2'b00, 32'd4});
    exp_q.push_back({1'b0, 2'b01, 32'd3});
    drain_per_clock("period0_seq");

    // Down across the wrap to -2, one edge per clock
    target = 32'hFFFF_FFFE; edge_period = 16'd1;
    exp_q.push_back({1'b0, 2'b11, 32'd2});
    exp_q.push_back({1'b0, 2'b10, 32'd1});
    exp_q.push_back({1'b1, 2'b00, 32'd0});
    exp_q.push_back({1'b0, 2'b01, 32'hFFFF_FFFF});
    exp_q.push_back({1'b0, 2'b11, 32'hFFFF_FFFE});
    drain_per_clock("down_wrap_seq");
    tick(); tick(); tick();
    check("wrap_hold_pos", pos, 32'hFFFF_FFFE);
    check("wrap_busy", busy, 0);

    // Loop-back into decoder model: +1000 then to -500, spacing 3
    do_reset();
    both_base = both_cnt;
    target = 32'd1000; edge_period = 16'd3; enable = 1'b1;
    wait_pos("loop_up_pos", 32'd1000, 3100);
    target = 32'hFFFF_FE0C;
    wait_pos("loop_down_pos", 32'hFFFF_FE0C, 5000);
    for (int i = 0; i < 8; i++) tick();
    check("loop_dec_pos", dec_pos, 32'hFFFF_FE0C);
    check("loop_single_toggle", both_cnt - both_base, 0);

    // Index with CPR=8: up to 20, then back to 0 (spacing 2 => 2 samples per count)
    do_reset();
    check("idx_rst", index, 1);
    target = 32'd20; edge_period = 16'd2; enable = 1'b1;
    exp_q.push_back(35'd8);  exp_q.push_back(35'd8);
    exp_q.push_back(35'd16); exp_q.push_back(35'd16);
    index_walk("idx_up", 32'd20, 100);
    target = 32'd0;
    exp_q.push_back(35'd16); exp_q.push_back(35'd16);
    exp_q.push_back(35'd8);  exp_q.push_back(35'd8);
    exp_q.push_back(35'd0);
    index_walk("idx_down", 32'd0, 100);

    // Mid-HOLD reversal with a new edge_period that must not disturb the timer
    do_reset();
    target = 32'd100; edge_period = 16'd10; enable = 1'b1;
    wait_pos("rev_reach7", 32'd7, 100);
    tick(); tick(); tick();
    target = 32'd0; edge_period = 16'd2;
    n = 3;
    while (pos == 32'd7 && n < 40) begin tick(); n++; end
    check("rev_gap", n, 10);
    check("rev_pos", pos, 6);
    check("rev_ab", {quadA, quadB}, 2'b11);
    n = 0;
    while (pos == 32'd6 && n < 40) begin tick(); n++; end
    check("new_period_gap", n, 2);
    check("new_period_pos", pos, 5);

    // enable=0 holds position; reset mid-motion snaps everything back
    do_reset();
    target = 32'd50; edge_period = 16'd1; enable = 1'b1;
    wait_pos("en_reach4", 32'd4, 20);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("en0_pos", pos, 4);
    check("en0_busy", busy, 0);
    check("en0_ab", {quadA, quadB}, 2'b00);
    enable = 1'b1; edge_period = 16'd3;
    tick();
    check("en1_resume", pos, 5);
    tick(); tick(); tick();
    check("en1_spacing", pos, 6);
    reset = 1'b1;
    tick();
    check("midrst_pos", pos, 0);
    check("midrst_ab", {quadA, quadB}, 2'b00);
    check("midrst_index", index, 1);
    check("midrst_state", dbg_state, 0);
    reset = 1'b0;

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
